// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: PC register, instruction ROM, next-PC formation
//
// Holds the PC of the single-cycle MIPS datapath, reads the instruction word at
// PC from a word-addressed ROM, and forms the next PC for sequential, branch,
// j/jal and jr flow.
//
// The ROM image is supplied through the IM_INIT parameter. Word 0 sits in the
// least significant 32 bits and lives at byte address PC_BASE. Words beyond
// IM_INIT_WORDS, up to the 2**IM_AW window, read as zero.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset, PC <= PC_BASE
//   stall        hold PC this edge
//   npc_op       00 seq, 01 branch, 10 j/jal, 11 jr
//   br_taken     branch condition, only used when npc_op=01
//   offset       branch offset field, Instr[15:0]
//   im26         jump index field, Instr[25:0]
//   jr_target    GPR[rs] value for jr
//   PC           current PC
//   PC4          PC+4, the jal link value
//   Instr        instruction word at PC, nop when PC is outside the ROM
//   pc_misalign  next-PC candidate has nonzero bits[1:0]
//   pc_oor       PC outside the ROM window
module ifu #(
  parameter logic [31:0]                 PC_BASE       = 32'h0000_3000,
  parameter int                          IM_AW         = 10,
  parameter int                          IM_INIT_WORDS = 16,
  parameter logic [IM_INIT_WORDS*32-1:0] IM_INIT       = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [15:0] offset,
  input  logic [25:0] im26,
  input  logic [31:0] jr_target,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic [31:0] Instr,
  output logic        pc_misalign,
  output logic        pc_oor
);

  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic [31:0]      pc_plus4;
  logic [31:0]      br_disp;
  logic [31:0]      npc;
  logic [29:0]      word_off;
  logic [IM_AW-1:0] idx;
  logic [31:0]      rom_word;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_disp  = {{14{offset[15]}}, offset, 2'b00};

  always_comb begin
    npc = pc_plus4;
    unique case (npc_op)
      2'b00: npc = pc_plus4;
      2'b01: npc = br_taken ? (pc_plus4 + br_disp) : pc_plus4;
      // j/jal take the region bits from the jump instruction's own PC
      2'b10: npc = {pc_q[31:28], im26, 2'b00};
      2'b11: npc = jr_target;
      default: npc = pc_plus4;
    endcase
  end

  // Low bits are dropped on load so PC can never hold a misaligned address.
  // Stall takes priority over any redirect presented this cycle.
  assign pc_d = stall ? pc_q : {npc[31:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= PC_BASE;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Word offset from the ROM base. A PC below the base wraps here, but pc_oor
  // catches that case through the explicit compare.
  assign word_off = pc_q[31:2] - PC_BASE[31:2];
  assign idx      = word_off[IM_AW-1:0];
  assign pc_oor   = (pc_q < PC_BASE) || (word_off[29:IM_AW] != '0);

  always_comb begin
    rom_word = 32'h0000_0000;
    for (int k = 0; k < IM_INIT_WORDS; k++) begin
      if (idx == IM_AW'(k)) begin
        rom_word = IM_INIT[k*32 +: 32];
      end
    end
  end

  assign PC          = pc_q;
  assign PC4         = pc_plus4;
  assign Instr       = pc_oor ? 32'h0000_0000 : rom_word;
  assign pc_misalign = |npc[1:0];

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - self-checking bench for ifu: directed flow steps plus randomized model comparison
module tb_ifu;

  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam logic [511:0] IMG = {
    32'h1000_ffff, 32'h0000_0008, 32'h03e0_0008, 32'h0c00_0c10,
    32'h0800_0c10, 32'h1022_fffc, 32'h8c43_0010, 32'hac43_0014,
    32'h3c01_1234, 32'h3421_5678, 32'h0022_1821, 32'h0062_2023,
    32'h1062_0003, 32'h2408_0005, 32'h3402_abcd, 32'h2001_0004
  };

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_op;
  logic        br_taken;
  logic [15:0] offset;
  logic [25:0] im26;
  logic [31:0] jr_target;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic [31:0] Instr;
  logic        pc_misalign;
  logic        pc_oor;

  int errors = 0;
  int checks = 0;
  logic [31:0]  m_pc;
  logic [511:0] img_v;

  ifu #(.PC_BASE(BASE), .IM_AW(10), .IM_INIT_WORDS(16), .IM_INIT(IMG)) dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .br_taken(br_taken),
    .offset(offset), .im26(im26), .jr_target(jr_target), .PC(PC), .PC4(PC4),
    .Instr(Instr), .pc_misalign(pc_misalign), .pc_oor(pc_oor)
  );

  always #5 clk = ~clk;

  function automatic logic model_oor(input logic [31:0] pc);
    return (pc < BASE) || (((pc - BASE) / 4) >= 1024);
  endfunction

  function automatic logic [31:0] model_instr(input logic [31:0] pc, input logic [511:0] img);
    int i;
    if (model_oor(pc)) return 32'h0;
    i = int'((pc - BASE) / 4);
    if (i < 16) return img[i*32 +: 32];
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [1:0] op,
                                            input logic bt, input logic [15:0] off,
                                            input logic [25:0] im, input logic [31:0] jr);
    logic signed [31:0] soff;
    logic [31:0] im32;
    soff = {{16{off[15]}}, off};
    im32 = {6'b0, im};
    case (op)
      2'b00:   return pc + 4;
      2'b01:   return bt ? pc + 4 + soff * 4 : pc + 4;
      2'b10:   return (pc & 32'hF000_0000) + im32 * 4;
      default: return jr;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_pc"}, PC, m_pc);
    chk({tag, "_pc4"}, PC4, m_pc + 4);
    chk({tag, "_instr"}, Instr, model_instr(m_pc, img_v));
    chk({tag, "_oor"}, {31'b0, pc_oor}, {31'b0, model_oor(m_pc)});
  endtask

  task automatic chk_pre(input string tag);
    logic [31:0] n;
    n = model_npc(m_pc, npc_op, br_taken, offset, im26, jr_target);
    chk_state(tag);
    chk({tag, "_misalign"}, {31'b0, pc_misalign}, {31'b0, |n[1:0]});
  endtask

  // Drive at the falling edge, settle, and leave time before the next rising edge.
  task automatic set_in(input logic [1:0] op, input logic bt, input logic [15:0] off,
                        input logic [25:0] im, input logic [31:0] jr, input logic st);
    npc_op = op; br_taken = bt; offset = off; im26 = im; jr_target = jr; stall = st;
    #1;
  endtask

  task automatic step(input string tag);
    logic [31:0] n;
    chk_pre({tag, "_pre"});
    n = model_npc(m_pc, npc_op, br_taken, offset, im26, jr_target);
    @(posedge clk);
    if (reset) m_pc = BASE;
    else if (!stall) m_pc = n & 32'hFFFF_FFFC;
    #1;
    chk_state({tag, "_post"});
    @(negedge clk);
  endtask

  initial begin
    img_v = IMG;
    reset = 1'b1;
    m_pc  = BASE;
    set_in(2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst_pc", PC, 32'h0000_3000);
    chk("rst_pc4", PC4, 32'h0000_3004);
    chk("rst_instr", Instr, 32'h2001_0004);
    chk("rst_misalign", {31'b0, pc_misalign}, 32'h0);
    chk("rst_oor", {31'b0, pc_oor}, 32'h0);

    // Sequential fetch
    reset = 1'b0;
    set_in(2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    step("seq1"); chk("seq1_const", PC, 32'h3004); chk("seq1_i", Instr, 32'h3402_abcd);
    step("seq2"); chk("seq2_const", PC, 32'h3008); chk("seq2_i", Instr, 32'h2408_0005);
    step("seq3"); chk("seq3_const", PC, 32'h300C); chk("seq3_i", Instr, 32'h1062_0003);
    step("seq4"); chk("seq4_const", PC, 32'h3010);

    // Backward branch taken, then not taken from the same PC
    set_in(2'b01, 1'b1, 16'hFFFC, 26'h0, 32'h0, 1'b0);
    step("br_t"); chk("br_t_const", PC, 32'h3004);
    set_in(2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    repeat (3) step("seq");
    chk("br_at", PC, 32'h3010);
    set_in(2'b01, 1'b0, 16'hFFFC, 26'h0, 32'h0, 1'b0);
    step("br_nt"); chk("br_nt_const", PC, 32'h3014);

    // Jump from 3020
    set_in(2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    repeat (3) step("seq");
    set_in(2'b10, 1'b0, 16'h0, 26'h000_0C10, 32'h0, 1'b0);
    chk("j_pc", PC, 32'h3020);
    chk("j_pc4", PC4, 32'h3024);
    step("j"); chk("j_const", PC, 32'h0000_3040);

    // jr with misaligned target, then jr below the ROM window
    set_in(2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_3106, 1'b0);
    chk("jr_misalign", {31'b0, pc_misalign}, 32'h1);
    step("jr1"); chk("jr1_const", PC, 32'h3104);
    set_in(2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_2FFC, 1'b0);
    step("jr2");
    chk("jr2_oor", {31'b0, pc_oor}, 32'h1);
    chk("jr2_instr", Instr, 32'h0);

    // Stall holds PC against a pending jump; the release applies it once
    set_in(2'b10, 1'b0, 16'h0, 26'h000_0C10, 32'h0, 1'b0);
    step("j_back"); chk("j_back_const", PC, 32'h3040);
    set_in(2'b10, 1'b0, 16'h0, 26'h000_0C20, 32'h0, 1'b1);
    step("stall1"); step("stall2");
    chk("stall_const", PC, 32'h3040);
    set_in(2'b10, 1'b0, 16'h0, 26'h000_0C20, 32'h0, 1'b0);
    step("unstall"); chk("unstall_const", PC, 32'h3080);
    set_in(2'b10, 1'b0, 16'h0, 26'h000_0C10, 32'h0, 1'b0);
    step("j_3040");

    // Asynchronous reset between edges, with stall asserted
    set_in(2'b01, 1'b1, 16'h0010, 26'h0, 32'h0, 1'b1);
    #1;
    reset = 1'b1;
    m_pc  = BASE;
    #1;
    chk("async_rst_pc", PC, 32'h3000);
    @(posedge clk);
    #1;
    chk("rst_hold_pc", PC, 32'h3000);
    @(negedge clk);
    reset = 1'b0;
    set_in(2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    step("rel"); chk("rel_const", PC, 32'h3004);

    // Randomized flow against the model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] tgt;
      logic [1:0]  op;
      reset = ($urandom_range(0, 31) == 0);
      if (reset) m_pc = BASE;
      tgt = BASE - 32'h20 + 32'($urandom_range(0, 32'h1100));
      op  = 2'($urandom_range(0, 3));
      set_in(op, 1'($urandom_range(0, 1)), 16'($signed(int'($urandom_range(0, 40)) - 20)),
             26'(tgt >> 2), tgt | 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0),
             ($urandom_range(0, 4) == 0));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
